// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared encodings for the MULT/DIV sequencer
//
// Contents: FSM state codes, OP_MULT/OP_DIV request encodings,
//   default operand width and iteration count.
package mult_div_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_ITERS = 32;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_MULT_RUN = 3'd1;
   localparam logic [2:0] S_DIV_RUN  = 3'd2;
   localparam logic [2:0] S_DIV_FIX  = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division step
//
// Ports: rem_in/quo_in  current {R,Q} (R is WIDTH+1 bits)
//        divisor        divisor magnitude |B|
//        rem_out/quo_out {R,Q} after shift-left and trial subtract
module div_restore_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [2*WIDTH:0] shifted;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;

   always_comb begin
      shifted = {rem_in, quo_in} << 1;
      rem_sh  = shifted[2*WIDTH:WIDTH];
      trial   = rem_sh - {1'b0, divisor};
      // A clear top bit means the trial subtraction did not go negative.
      if (!trial[WIDTH]) begin
         rem_out = trial;
         quo_out = {shifted[WIDTH-1:1], 1'b1};
      end else begin
         rem_out = rem_sh;
         quo_out = shifted[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mult_div_ctrl.sv
// rtl/mult_div_ctrl.sv - MIPS MULT/DIV multicycle sequencer owning HI/LO
//
// Ports: clk, reset (synchronous, active-high)
//        start, op (0 MULT / 1 DIV), a_in, b_in: request, sampled in IDLE only
//        busy: iterating or fixing signs; done: one-cycle completion pulse
//        hi_out/lo_out: HI/LO registers; div_zero: divide-by-zero flag
// Optional: MULT_DIV_DIVZERO_EXC_EN enables the zero-divisor early exit and div_zero.
module mult_div_ctrl
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_zero
);

   logic [2:0]       state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic             last_step;

   // acc/mq are shared: Booth {acc, mq, q_m1} for MULT, remainder/quotient for DIV.
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] mq;
   logic             q_m1;
   // Sign-extended A for MULT, zero-extended |B| for DIV.
   logic [WIDTH:0]   mcand;
   logic             neg_q, neg_r;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   booth_sum;
   logic [WIDTH:0]   booth_acc;
   logic [WIDTH-1:0] booth_mq;
   logic             booth_qm1;
   logic [WIDTH:0]   div_rem;
   logic [WIDTH-1:0] div_quo;

   assign last_step = (cnt == CNT_W'(MD_ITERS - 1));
   assign a_mag     = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
   assign b_mag     = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

   always_comb begin
      booth_sum = acc;
      case ({mq[0], q_m1})
         2'b01:   booth_sum = acc + mcand;
         2'b10:   booth_sum = acc - mcand;
         default: booth_sum = acc;
      endcase
      // Arithmetic shift right of {sum, mq, q_m1}; old q_m1 falls off.
      {booth_acc, booth_mq, booth_qm1} = {booth_sum[WIDTH], booth_sum, mq};
   end

   div_restore_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  (acc),
      .quo_in  (mq),
      .divisor (mcand[WIDTH-1:0]),
      .rem_out (div_rem),
      .quo_out (div_quo)
   );

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MULT)
                  state_nx = S_MULT_RUN;
`ifdef MULT_DIV_DIVZERO_EXC_EN
               else if (b_in == '0)
                  state_nx = S_DONE;
`endif
               else
                  state_nx = S_DIV_RUN;
            end
         end
         S_MULT_RUN: if (last_step) state_nx = S_DONE;
         S_DIV_RUN:  if (last_step) state_nx = S_DIV_FIX;
         S_DIV_FIX:  state_nx = S_DONE;
         default:    state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi_out <= '0;
         lo_out <= '0;
         cnt    <= '0;
         acc    <= '0;
         mq     <= '0;
         q_m1   <= 1'b0;
         mcand  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
`ifdef MULT_DIV_DIVZERO_EXC_EN
         div_zero <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         busy  <= (state_nx == S_MULT_RUN) || (state_nx == S_DIV_RUN) ||
                  (state_nx == S_DIV_FIX);
         done  <= (state_nx == S_DONE);
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt  <= '0;
                  acc  <= '0;
                  q_m1 <= 1'b0;
                  if (op == OP_MULT) begin
                     mq    <= b_in;
                     mcand <= {a_in[WIDTH-1], a_in};
                  end else begin
                     mq    <= a_mag;
                     mcand <= {1'b0, b_mag};
                     neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                     neg_r <= a_in[WIDTH-1];
                  end
`ifdef MULT_DIV_DIVZERO_EXC_EN
                  div_zero <= (op == OP_DIV) && (b_in == '0);
`endif
               end
            end
            S_MULT_RUN: begin
               acc  <= booth_acc;
               mq   <= booth_mq;
               q_m1 <= booth_qm1;
               cnt  <= cnt + 1'b1;
               if (last_step) begin
                  hi_out <= booth_acc[WIDTH-1:0];
                  lo_out <= booth_mq;
               end
            end
            S_DIV_RUN: begin
               acc <= div_rem;
               mq  <= div_quo;
               cnt <= cnt + 1'b1;
            end
            S_DIV_FIX: begin
               lo_out <= neg_q ? (~mq + 1'b1) : mq;
               hi_out <= neg_r ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

`ifndef MULT_DIV_DIVZERO_EXC_EN
   assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb/tb_mult_div_ctrl.sv - self-checking bench for mult_div_ctrl
module tb_mult_div_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        div_zero;

   int checks   = 0;
   int failures = 0;

   logic [31:0] hi_m = 32'h0;
   logic [31:0] lo_m = 32'h0;

   mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a_in     (a_in),
      .b_in     (b_in),
      .busy     (busy),
      .done     (done),
      .hi_out   (hi_out),
      .lo_out   (lo_out),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference results from plain signed arithmetic.
   task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el,
                        output logic ez, output int elat);
      longint      sa, sb, p;
      logic [31:0] am, bm, qm, rm;
      ez = 1'b0;
      if (o == 1'b0) begin
         sa   = longint'($signed(a));
         sb   = longint'($signed(b));
         p    = sa * sb;
         eh   = p[63:32];
         el   = p[31:0];
         elat = 33;
      end else begin
         am   = a[31] ? (32'h0 - a) : a;
         bm   = b[31] ? (32'h0 - b) : b;
         elat = 34;
         if (bm == 32'h0) begin
            qm = 32'hFFFF_FFFF;
            rm = am;
         end else begin
            qm = am / bm;
            rm = am % bm;
         end
         el = (a[31] ^ b[31]) ? (32'h0 - qm) : qm;
         eh = a[31] ? (32'h0 - rm) : rm;
`ifdef MULT_DIV_DIVZERO_EXC_EN
         if (b == 32'h0) begin
            eh   = hi_m;
            el   = lo_m;
            ez   = 1'b1;
            elat = 1;
         end
`endif
      end
   endtask

   task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input bit noise);
      logic [31:0] eh, el;
      logic        ez;
      int          elat, lat, bc;
      model(o, a, b, eh, el, ez, elat);
      op    = o;
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      step();
      start = 1'b0;
      a_in  = $urandom;
      b_in  = $urandom;
      chk("div_zero_t1", {63'h0, div_zero}, {63'h0, (elat == 1) ? ez : 1'b0});
      lat = 1;
      bc  = 0;
      while (!done && lat < 40) begin
         if (busy) bc++;
         if (noise && lat == 5) begin
            start = 1'b1;
            op    = ~o;
         end else begin
            start = 1'b0;
         end
         step();
         lat++;
      end
      start = 1'b0;
      chk("latency", 64'(lat), 64'(elat));
      chk("busy_cycles", 64'(bc), 64'(elat - 1));
      chk("busy_at_done", {63'h0, busy}, 64'h0);
      chk("hi", {32'h0, hi_out}, {32'h0, eh});
      chk("lo", {32'h0, lo_out}, {32'h0, el});
      chk("div_zero", {63'h0, div_zero}, {63'h0, ez});
      hi_m = eh;
      lo_m = el;
      // A start in the DONE cycle must be ignored.
      start = 1'b1;
      op    = 1'($urandom_range(0, 1));
      a_in  = $urandom;
      b_in  = $urandom;
      step();
      start = 1'b0;
      chk("done_after", {63'h0, done}, 64'h0);
      chk("busy_after", {63'h0, busy}, 64'h0);
      chk("hi_hold", {32'h0, hi_out}, {32'h0, eh});
   endtask

   initial begin
      bit seen_done;
      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a_in  = 32'h0;
      b_in  = 32'h0;
      repeat (3) step();
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      chk("rst_hi", {32'h0, hi_out}, 64'h0);
      chk("rst_lo", {32'h0, lo_out}, 64'h0);
      chk("rst_dz", {63'h0, div_zero}, 64'h0);
      reset = 1'b0;
      step();

      run_op(1'b0, 32'h0000_0003, 32'hFFFF_FFFB, 1'b0);
      run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);
      run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      run_op(1'b1, 32'h0000_0007, 32'h0000_0000, 1'b0);
      run_op(1'b0, 32'h1234_5678, 32'h0000_0010, 1'b0);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op(1'b1, 32'h8000_0001, 32'h0000_0000, 1'b0);
      run_op(1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0);

      for (int i = 0; i < 12; i++) begin
         logic        ro;
         logic [31:0] ra, rb;
         ro = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'h0;
            1:       rb = $urandom_range(0, 1) ? 32'($urandom_range(1, 9))
                                               : 32'h0 - 32'($urandom_range(1, 9));
            default: rb = $urandom;
         endcase
         run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
      end

      // Reset in mid-operation discards the result and never pulses done.
      op    = 1'b0;
      a_in  = 32'h0000_1234;
      b_in  = 32'h0000_5678;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      start = 1'b1;
      op    = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_busy", {63'h0, busy}, 64'h0);
      chk("mid_rst_done", {63'h0, done}, 64'h0);
      chk("mid_rst_hi", {32'h0, hi_out}, 64'h0);
      chk("mid_rst_lo", {32'h0, lo_out}, 64'h0);
      chk("mid_rst_dz", {63'h0, div_zero}, 64'h0);
      hi_m = 32'h0;
      lo_m = 32'h0;
      seen_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (done || busy) seen_done = 1'b1;
         step();
      end
      chk("no_done_after_rst", {63'h0, seen_done}, 64'h0);

      run_op(1'b1, 32'h0000_0007, 32'h0000_0000, 1'b0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Multicycle sequencer for the MIPS MULT/DIV resource. The main control unit issues a one-cycle `start` from its execute state and waits on `done`. The block then iterates a radix-2 Booth multiplier or a restoring divider over the A/B register operands, one step per cycle, and loads the HI/LO registers. It owns HI/LO; MFHI/MFLO read `hi_out`/`lo_out` through the register-write mux.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits.
- `CNT_W`, 6: iteration counter width; must hold `WIDTH`.
- `clk` in 1: single clock; every flop is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; accepted only in IDLE.
- `op` in 1: 0 = MULT, 1 = DIV; sampled with `start`.
- `a_in` in WIDTH: multiplicand or dividend (register A); sampled with `start`.
- `b_in` in WIDTH: multiplier or divisor (register B); sampled with `start`.
- `busy` out 1: high in MULT_RUN, DIV_RUN and DIV_FIX.
- `done` out 1: one-cycle pulse in the DONE state.
- `hi_out` out WIDTH: HI register (product high half, or remainder).
- `lo_out` out WIDTH: LO register (product low half, or quotient).
- `div_zero` out 1: divide-by-zero flag (see Configuration).

## Operation
- States: IDLE, MULT_RUN, DIV_RUN, DIV_FIX, DONE.
- Reset values: state IDLE, `busy` = 0, `done` = 0, `div_zero` = 0, `hi_out` = 0, `lo_out` = 0, counter = 0.
- IDLE → MULT_RUN on `start` with `op` = 0.
- IDLE → DIV_RUN on `start` with `op` = 1.
- MULT_RUN → DONE after 32 iterations.
- DIV_RUN → DIV_FIX after 32 iterations.
- DIV_FIX → DONE.
- DONE → IDLE unconditionally.
- `start` outside IDLE is ignored, including in DONE. Operand changes after acceptance are ignored.
- MULT is signed, Booth radix-2:
  - 33-bit sign-extended accumulator; product register {acc, multiplier, q-1}.
  - Each step examines the low 2 bits: 01 adds A, 10 subtracts A, then arithmetic shift right by 1.
  - After 32 steps: HI = product[63:32], LO = product[31:0].
- DIV is signed restoring division on magnitudes:
  - 33-bit remainder, 32-bit quotient.
  - Each step shifts {R,Q} left by 1 and trial-subtracts |B|. If the result is non-negative, keep it and set Q[0] = 1.
  - DIV_FIX negates the quotient when a[31]^b[31], and negates the remainder when a[31].
  - Results: HI = remainder, LO = quotient.
  - −2^31 / −1 wraps: LO = 0x80000000, HI = 0.
- HI/LO change only on the edge entering DONE. They hold until the next completed operation or reset.
- `div_zero` is set entering DONE (DIV with zero divisor only). It clears on the next accepted `start` or on reset.
- `reset` in any state returns the block to reset values on that edge. A partial result is discarded and `done` is not pulsed.

## Timing
- `start` sampled high in cycle T.
- MULT:
  - `busy` high in cycles T+1..T+32.
  - `done` high in T+33 with `busy` low; HI/LO valid from T+33.
- DIV:
  - `busy` high in T+1..T+33 (DIV_FIX is T+33).
  - `done` high in T+34; HI/LO valid from T+34.
- Earliest next accepted `start`: T+34 (MULT) or T+35 (DIV).
- All outputs are registered; nothing is combinational from the inputs.

## Configuration
- `MULT_DIV_DIVZERO_EXC_EN` defined:
  - A DIV with `b_in` = 0 skips iteration and goes IDLE → DONE. `done` and `div_zero` are high in T+1.
  - HI/LO are unchanged.
  - The control unit uses `div_zero` to enter its exception path.
- Macro undefined:
  - No zero check; `div_zero` is tied to 0.
  - A zero divisor runs the full 34-cycle DIV. The magnitude algorithm yields quotient magnitude 0xFFFFFFFF and remainder |A|, and DIV_FIX then applies the normal sign rules.

## Structure
- Shared package `mult_div_pkg` holds:
  - state encoding localparams;
  - OP_MULT/OP_DIV encodings;
  - WIDTH and iteration count (32).
- The control unit includes the package for its `op` encoding.
- One sub-module, `div_restore_step`: combinational single restoring step. Input {R,Q} and |B|; output the next {R,Q}.
- The Booth step, counter and FSM stay in `mult_div_ctrl`.

## Test plan
- MULT 3 × −5 (a = 0x00000003, b = 0xFFFFFFFB) → `done` at T+33, HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0x00000000; `busy` high for exactly 32 cycles.
- DIV −7 / 2 (a = 0xFFFFFFF9, b = 2) → `done` at T+34, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, `div_zero` = 0.
- DIV 7 / 0:
  - With the macro → `done` and `div_zero` at T+1, HI/LO keep their prior values.
  - Without the macro → `done` at T+34, LO = 0xFFFFFFFF, HI = 7, `div_zero` = 0.
- MULT started, `start` (op = DIV) pulsed at T+5, `reset` asserted at T+10:
  - The T+5 request is ignored.
  - At T+11: `busy` = 0, HI = LO = 0, state IDLE, and no `done` pulse ever appears.
- Back-to-back: MULT completes (`done` at T+33), a new `start` in the DONE cycle is ignored, and a `start` at T+34 is accepted. `div_zero` from a prior divide-by-zero clears on that accepted `start`.
